// File: rtl/hv_encode_accumulator.sv
// hv_encode_accumulator
// Sums signed per-lane partial sums over the beats of one hypervector chunk,
// turns each lane into one bit by its sign, and hands the chunk plus its
// buffer address downstream over valid/ready. After NUM_CHUNKS chunks the
// block parks in DONE until reset.
module hv_encode_accumulator #(
  parameter int LANES            = 16,
  parameter int PSUM_WIDTH       = 16,
  parameter int ACC_WIDTH        = 24,
  parameter int BEATS_PER_CHUNK  = 16,
  parameter int NUM_CHUNKS       = 250,
  parameter int CHUNK_ADDR_WIDTH = 8
) (
  input  logic                                 clk,
  input  logic                                 reset_in,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [LANES-1:0][PSUM_WIDTH-1:0]     in_psum,
  input  logic                                 in_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [LANES-1:0]                     out_chunk,
  output logic [CHUNK_ADDR_WIDTH-1:0]          out_addr,
  output logic                                 out_done,
  output logic                                 sat_err,
  output logic                                 frame_err
);

  localparam int BEAT_CNT_WIDTH = $clog2(BEATS_PER_CHUNK + 1);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [BEAT_CNT_WIDTH-1:0] LAST_BEAT_IDX = BEAT_CNT_WIDTH'(BEATS_PER_CHUNK - 1);
  localparam logic [CHUNK_ADDR_WIDTH-1:0] LAST_CHUNK_IDX = CHUNK_ADDR_WIDTH'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    ST_ACCUM,
    ST_EMIT,
    ST_DONE
  } state_t;

  state_t                      r_state;
  state_t                      w_state_next;

  logic [ACC_WIDTH-1:0]        r_acc [LANES];
  logic [BEAT_CNT_WIDTH-1:0]   r_beat_cnt;
  logic [CHUNK_ADDR_WIDTH-1:0] r_chunk_cnt;
  logic [LANES-1:0]            r_out_chunk;
  logic [CHUNK_ADDR_WIDTH-1:0] r_out_addr;
  logic                        r_sat_err;
  logic                        r_frame_err;

  // One extra bit of headroom so the raw sum never wraps before the clamp test.
  logic [ACC_WIDTH:0]          w_wide     [LANES];
  logic [ACC_WIDTH-1:0]        w_acc_next [LANES];
  logic [LANES-1:0]            w_lane_sat;
  logic [LANES-1:0]            w_chunk_bits;

  logic w_beat_fire;
  logic w_out_fire;
  logic w_last_beat;
  logic w_close;
  logic w_final_chunk;

  // Handshake qualifiers are derived from the state register, not from the
  // output ports, so no combinational path loops through in_ready/out_valid.
  assign w_beat_fire   = in_valid  && (r_state == ST_ACCUM);
  assign w_out_fire    = out_ready && (r_state == ST_EMIT);
  assign w_last_beat   = (r_beat_cnt == LAST_BEAT_IDX);
  assign w_close       = w_beat_fire && (in_last || w_last_beat);
  assign w_final_chunk = (r_chunk_cnt == LAST_CHUNK_IDX);

  // Per-lane saturating add of the sign-extended partial sum, and the sign bit
  // of the result (zero counts as non-negative, so it maps to 1).
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_wide[i] = {r_acc[i][ACC_WIDTH-1], r_acc[i]}
                + {{(ACC_WIDTH + 1 - PSUM_WIDTH){in_psum[i][PSUM_WIDTH-1]}}, in_psum[i]};
      w_lane_sat[i] = w_wide[i][ACC_WIDTH] ^ w_wide[i][ACC_WIDTH-1];
      if (w_lane_sat[i]) begin
        w_acc_next[i] = w_wide[i][ACC_WIDTH] ? ACC_MIN : ACC_MAX;
      end else begin
        w_acc_next[i] = w_wide[i][ACC_WIDTH-1:0];
      end
      w_chunk_bits[i] = ~w_acc_next[i][ACC_WIDTH-1];
    end
  end

  // Next-state and handshake/status outputs decoded from the current state.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_done     = 1'b0;
    unique case (r_state)
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (w_close) begin
          w_state_next = ST_EMIT;
        end
      end
      ST_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = w_final_chunk ? ST_DONE : ST_ACCUM;
        end
      end
      ST_DONE: begin
        out_done = 1'b1;
      end
      default: begin
        w_state_next = ST_ACCUM;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset_in) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Accumulators, counters, registered chunk/address and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      // NOTE: the accumulator array is a bank of flops, not a RAM, and a reset
      // mid-chunk must discard partial sums, so every lane is cleared here.
      for (int i = 0; i < LANES; i++) begin
        r_acc[i] <= '0;
      end
      r_beat_cnt  <= '0;
      r_chunk_cnt <= '0;
      r_out_chunk <= '0;
      r_out_addr  <= '0;
      r_sat_err   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_beat_fire) begin
        for (int i = 0; i < LANES; i++) begin
          r_acc[i] <= w_acc_next[i];
        end
        r_beat_cnt <= r_beat_cnt + 1'b1;
        if (|w_lane_sat) begin
          r_sat_err <= 1'b1;
        end
        if (w_close) begin
          r_out_chunk <= w_chunk_bits;
          r_out_addr  <= r_chunk_cnt;
          if (w_last_beat && !in_last) begin
            r_frame_err <= 1'b1;
          end
        end
      end
      if (w_out_fire) begin
        for (int i = 0; i < LANES; i++) begin
          r_acc[i] <= '0;
        end
        r_beat_cnt <= '0;
        if (!w_final_chunk) begin
          r_chunk_cnt <= r_chunk_cnt + 1'b1;
        end
      end
    end
  end

  assign out_chunk = r_out_chunk;
  assign out_addr  = r_out_addr;
  assign sat_err   = r_sat_err;
  assign frame_err = r_frame_err;

endmodule
